sigma_delta_ctrl: RTL and testbench

//  Sequencer in front of sigma_delta_core. Buffers incoming modulator values in a small FIFO.

---
 rtl/sigma_delta_pkg.sv | 24 ++
 rtl/sigma_delta_fifo.sv | 59 +++++
 rtl/sigma_delta_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_sigma_delta_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sigma_delta_pkg.sv
// +--------------------------------------------------------------------------+
// | sigma_delta_pkg : shared types and constants for the sigma-delta control |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package sigma_delta_pkg;

  localparam int UNDERRUN_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  function automatic int unsigned mid_value(input int unsigned vw);
    return 32'd1 << (vw - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sigma_delta_fifo.sv
// +--------------------------------------------------------------------------+
// | sigma_delta_fifo : synchronous FIFO with push/pop/flush and head output   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module sigma_delta_fifo
  import sigma_delta_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_wr_en;
  logic             w_rd_en;

  assign empty   = (r_wr_ptr == r_rd_ptr);
  assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_wr_en = push && !full && !flush;
  assign w_rd_en = pop && !empty;
  assign head    = r_mem[r_rd_ptr[AW-1:0]];

  // A flush wins over a same-cycle push; a same-cycle pop has already sampled head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/sigma_delta_ctrl.sv
// +--------------------------------------------------------------------------+
// | sigma_delta_ctrl : frame-aligned sequencer feeding sigma_delta_core       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module sigma_delta_ctrl
  import sigma_delta_pkg::*;
#(
  parameter int VALUE_WIDTH   = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int HOLD_FRAMES   = 1,
  parameter int WARMUP_FRAMES = 2
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      run,
  input  logic                      flush,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [VALUE_WIDTH-1:0]    s_value,
  output logic                      core_enable,
  output logic [VALUE_WIDTH-1:0]    core_value,
  output logic                      frame_start,
  output logic                      busy,
  output logic                      underrun,
  output logic [UNDERRUN_CNT_W-1:0] underrun_cnt
);

  localparam logic [VALUE_WIDTH-1:0] c_mid    = VALUE_WIDTH'(mid_value(VALUE_WIDTH));
  localparam int                     c_hold_w = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam int                     c_warm_w = (WARMUP_FRAMES > 1) ? $clog2(WARMUP_FRAMES) : 1;

  logic [1:0]                r_rst_sync;
  logic                      w_rst_n;

  state_t                    r_state,     w_state_nxt;
  logic                      r_enable,    w_enable_nxt;
  logic [VALUE_WIDTH-1:0]    r_value,     w_value_nxt;
  logic [VALUE_WIDTH-1:0]    r_frame_cnt, w_frame_cnt_nxt;
  logic [c_hold_w-1:0]       r_hold_cnt,  w_hold_cnt_nxt;
  logic [c_warm_w-1:0]       r_warm_cnt,  w_warm_cnt_nxt;
  logic                      r_underrun,  w_underrun_nxt;
  logic [UNDERRUN_CNT_W-1:0] r_ucnt,      w_ucnt_nxt;

  logic                      w_boundary;
  logic                      w_load;
  logic                      w_pop;
  logic                      w_full;
  logic                      w_empty;
  logic [VALUE_WIDTH-1:0]    w_head;

  // Reset asserts immediately but releases only on a clock edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_rst_sync <= 2'b00;
    else         r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  sigma_delta_fifo #(
    .WIDTH (VALUE_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (w_rst_n),
    .push  (s_valid),
    .pop   (w_pop),
    .flush (flush),
    .din   (s_value),
    .head  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  assign w_boundary = r_enable && (r_frame_cnt == {VALUE_WIDTH{1'b1}});

  always_comb begin
    w_state_nxt     = r_state;
    w_enable_nxt    = r_enable;
    w_value_nxt     = r_value;
    w_frame_cnt_nxt = r_enable ? r_frame_cnt + VALUE_WIDTH'(1) : r_frame_cnt;
    w_hold_cnt_nxt  = r_hold_cnt;
    w_warm_cnt_nxt  = r_warm_cnt;
    w_underrun_nxt  = 1'b0;
    w_ucnt_nxt      = r_ucnt;
    w_load          = 1'b0;
    w_pop           = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (run) begin
          w_state_nxt     = ST_WARMUP;
          w_enable_nxt    = 1'b1;
          w_value_nxt     = c_mid;
          w_frame_cnt_nxt = '0;
          w_warm_cnt_nxt  = '0;
          w_hold_cnt_nxt  = '0;
          w_ucnt_nxt      = '0;
        end
      end
      ST_WARMUP: begin
        if (!run) begin
          w_state_nxt = w_boundary ? ST_IDLE : ST_STOP;
        end else if (w_boundary) begin
          if (r_warm_cnt == c_warm_w'(WARMUP_FRAMES - 1)) begin
            w_state_nxt    = ST_RUN;
            w_hold_cnt_nxt = '0;
            w_load         = 1'b1;
          end else begin
            w_warm_cnt_nxt = r_warm_cnt + c_warm_w'(1);
          end
        end
      end
      ST_RUN: begin
        if (!run) begin
          w_state_nxt = w_boundary ? ST_IDLE : ST_STOP;
        end else if (w_boundary) begin
          if (r_hold_cnt == c_hold_w'(HOLD_FRAMES - 1)) begin
            w_hold_cnt_nxt = '0;
            w_load         = 1'b1;
          end else begin
            w_hold_cnt_nxt = r_hold_cnt + c_hold_w'(1);
          end
        end
      end
      ST_STOP: begin
        if (w_boundary) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Leaving to IDLE from an enabled state always ends exactly at a frame boundary.
    if (r_state != ST_IDLE && w_state_nxt == ST_IDLE) begin
      w_enable_nxt    = 1'b0;
      w_value_nxt     = '0;
      w_frame_cnt_nxt = '0;
    end

    if (w_load) begin
      if (!w_empty) begin
        w_pop       = 1'b1;
        w_value_nxt = w_head;
      end else begin
        w_underrun_nxt = 1'b1;
        if (r_ucnt != {UNDERRUN_CNT_W{1'b1}}) w_ucnt_nxt = r_ucnt + UNDERRUN_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state     <= ST_IDLE;
      r_enable    <= 1'b0;
      r_value     <= '0;
      r_frame_cnt <= '0;
      r_hold_cnt  <= '0;
      r_warm_cnt  <= '0;
      r_underrun  <= 1'b0;
      r_ucnt      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_enable    <= w_enable_nxt;
      r_value     <= w_value_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_hold_cnt  <= w_hold_cnt_nxt;
      r_warm_cnt  <= w_warm_cnt_nxt;
      r_underrun  <= w_underrun_nxt;
      r_ucnt      <= w_ucnt_nxt;
    end
  end

  assign s_ready      = !w_full;
  assign core_enable  = r_enable;
  assign core_value   = r_value;
  assign frame_start  = r_enable && (r_frame_cnt == '0);
  assign busy         = (r_state != ST_IDLE);
  assign underrun     = r_underrun;
  assign underrun_cnt = r_ucnt;

endmodule

`default_nettype wire

// File: tb/tb_sigma_delta_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_sigma_delta_ctrl : vector table plus value scoreboard for the control  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_sigma_delta_ctrl;

  localparam int VW     = 8;
  localparam int WARMUP = 2;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          run = 1'b0;
  logic          flush = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [VW-1:0] s_value = '0;
  logic          core_enable;
  logic [VW-1:0] core_value;
  logic          frame_start;
  logic          busy;
  logic          underrun;
  logic [15:0]   underrun_cnt;

  always #5 clk = ~clk;

  sigma_delta_ctrl #(
    .VALUE_WIDTH   (VW),
    .FIFO_DEPTH    (4),
    .HOLD_FRAMES   (1),
    .WARMUP_FRAMES (WARMUP)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .run          (run),
    .flush        (flush),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_value      (s_value),
    .core_enable  (core_enable),
    .core_value   (core_value),
    .frame_start  (frame_start),
    .busy         (busy),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  int total = 0;
  int bad   = 0;
  int q[$];
  bit mon_en = 1'b0;
  int fidx = 0;
  logic [VW-1:0] last_val = '0;
  int cyc = 0;
  int base = 0;

  typedef struct {
    int          k;
    logic        run;
    logic        en;
    logic [7:0]  val;
    logic        fs;
    logic        ur;
    logic [15:0] ucnt;
  } vec_t;
  vec_t vec[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard: each load boundary pops the oldest accepted word, or flags an underrun.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!core_enable) begin
        fidx = 0;
      end else if (frame_start) begin
        if (fidx < WARMUP) begin
          check("sb_warmup_value", core_value, 128);
        end else if (q.size() == 0) begin
          check("sb_underrun", underrun, 1);
        end else begin
          check("sb_underrun", underrun, 0);
          check("sb_value", core_value, q.pop_front());
        end
        fidx++;
      end else begin
        check("sb_hold_midframe", core_value, last_val);
      end
      last_val = core_value;
    end
  end

  task automatic wait_k(input int k);
    while (cyc - base - 1 < k) @(negedge clk);
  endtask

  task automatic push_word(input logic [VW-1:0] v, input bit to_sb);
    s_valid = 1'b1;
    s_value = v;
    if (s_ready && to_sb) q.push_back(int'(v));
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic start_run();
    run  = 1'b1;
    base = cyc;
    @(negedge clk);
  endtask

  initial begin
    int n;
    vec[0]  = '{0,    1'b1, 1'b1, 8'd128, 1'b1, 1'b0, 16'd0};
    vec[1]  = '{255,  1'b1, 1'b1, 8'd128, 1'b0, 1'b0, 16'd0};
    vec[2]  = '{256,  1'b1, 1'b1, 8'd128, 1'b1, 1'b0, 16'd0};
    vec[3]  = '{511,  1'b1, 1'b1, 8'd128, 1'b0, 1'b0, 16'd0};
    vec[4]  = '{512,  1'b1, 1'b1, 8'd10,  1'b1, 1'b0, 16'd0};
    vec[5]  = '{767,  1'b1, 1'b1, 8'd10,  1'b0, 1'b0, 16'd0};
    vec[6]  = '{768,  1'b1, 1'b1, 8'd20,  1'b1, 1'b0, 16'd0};
    vec[7]  = '{1024, 1'b1, 1'b1, 8'd30,  1'b1, 1'b0, 16'd0};
    vec[8]  = '{1279, 1'b1, 1'b1, 8'd30,  1'b0, 1'b0, 16'd0};
    vec[9]  = '{1280, 1'b1, 1'b1, 8'd30,  1'b1, 1'b1, 16'd1};
    vec[10] = '{1281, 1'b1, 1'b1, 8'd30,  1'b0, 1'b0, 16'd1};
    vec[11] = '{1536, 1'b1, 1'b1, 8'd30,  1'b1, 1'b1, 16'd2};
    vec[12] = '{1792, 1'b1, 1'b1, 8'd30,  1'b1, 1'b1, 16'd3};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_enable", core_enable, 0);
    check("rst_value", core_value, 0);
    check("rst_ready", s_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_ucnt", underrun_cnt, 0);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    mon_en = 1'b1;

    // Warm-up, three loads, then underruns every frame
    push_word(8'd10, 1'b1);
    push_word(8'd20, 1'b1);
    push_word(8'd30, 1'b1);
    start_run();
    check("busy_after_run", busy, 1);
    foreach (vec[i]) begin
      wait_k(vec[i].k);
      run = vec[i].run;
      check("vec_enable", core_enable, vec[i].en);
      check("vec_value", core_value, vec[i].val);
      check("vec_frame_start", frame_start, vec[i].fs);
      check("vec_underrun", underrun, vec[i].ur);
      check("vec_ucnt", underrun_cnt, vec[i].ucnt);
    end

    // Stop at frame_cnt=100: 155 more enabled clocks, words pushed while stopping are kept
    wait_k(1892);
    run = 1'b0;
    push_word(8'd7, 1'b1);
    push_word(8'd9, 1'b1);
    check("stop_enabled_early", core_enable, 1);
    n = 0;
    repeat (153) begin
      @(negedge clk);
      if (core_enable) n++;
    end
    check("stop_enabled_count", n, 153);
    @(negedge clk);
    check("stop_enable_off", core_enable, 0);
    check("stop_value_zero", core_value, 0);
    check("stop_busy", busy, 0);

    // Fill to full; the fifth word must not be stored
    push_word(8'd11, 1'b1);
    check("ready_three_words", s_ready, 1);
    push_word(8'd13, 1'b1);
    check("full_after_four", s_ready, 0);
    push_word(8'd99, 1'b1);
    check("full_still", s_ready, 0);

    start_run();
    check("ucnt_cleared", underrun_cnt, 0);
    wait_k(513);
    check("ready_after_pop", s_ready, 1);

    // Async reset mid-frame in RUN
    wait_k(1330);
    mon_en = 1'b0;
    #1 resetn = 1'b0;
    #1;
    check("arst_enable", core_enable, 0);
    check("arst_value", core_value, 0);
    check("arst_busy", busy, 0);
    check("arst_frame_start", frame_start, 0);
    check("arst_ready", s_ready, 1);
    check("arst_queue_drained", q.size(), 0);
    q.delete();
    run = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_enable", core_enable, 0);
    mon_en = 1'b1;

    // Flush empties a full FIFO; a push coinciding with flush is dropped
    repeat (4) push_word(8'd55, 1'b0);
    check("full_before_flush", s_ready, 0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("ready_after_flush", s_ready, 1);
    s_valid = 1'b1;
    s_value = 8'd77;
    flush   = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    flush   = 1'b0;
    start_run();
    wait_k(513);
    check("flush_push_dropped_ucnt", underrun_cnt, 1);
    check("flush_value_held", core_value, 128);
    run = 1'b0;
    n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("final_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
